// File: rtl/scratchpad_memory_arbiter.sv
`default_nettype none
// scratchpad_memory_arbiter: round-robin requester arbitration into scratchpad stage 1,
// in-order response routing, outstanding limit and drain handshake.  Rev 1.0
module scratchpad_memory_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int PAYLOAD_W       = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clock,
  input  logic                                 resetn,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]         req_payload,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic                                 sm_valid,
  output logic [PAYLOAD_W-1:0]                 sm_payload,
  input  logic                                 sm_ready,
  input  logic                                 rsp_valid,
  input  logic                                 rsp_is_last,
  output logic [NUM_REQ-1:0]                   rsp_valid_out,
  output logic [NUM_REQ-1:0]                   rsp_last_out,
  input  logic                                 drain_req,
  output logic                                 drain_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DRAINED = 2'd2} state_t;

  state_t               state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      grant_id;
  logic [ID_W-1:0]      head_id;
  logic [ID_W-1:0]      id_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PAYLOAD_W-1:0] grant_payload;
  logic                 found;
  logic                 can_grant;
  logic                 grant;
  logic                 retire;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     outstanding_next;
  logic                 sm_valid_next;

  // The ID FIFO occupancy always equals the outstanding count, so it doubles as the FIFO level.
  assign fifo_empty = (outstanding == '0);
  assign can_grant  = (state == RUN) && (!sm_valid || sm_ready) &&
                      (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign grant      = can_grant && found;
  assign retire     = rsp_valid && rsp_is_last && !fifo_empty;
  assign head_id    = id_fifo[rd_ptr];

  always_comb begin
    int idx;
    idx           = 0;
    found         = 1'b0;
    grant_id      = '0;
    grant_payload = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found         = 1'b1;
        grant_id      = ID_W'(idx);
        grant_payload = req_payload[idx*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  always_comb begin
    req_ready     = '0;
    rsp_valid_out = '0;
    rsp_last_out  = '0;
    if (grant) req_ready[grant_id] = 1'b1;
    if (rsp_valid && !fifo_empty) begin
      rsp_valid_out[head_id] = 1'b1;
      rsp_last_out[head_id]  = rsp_is_last;
    end
  end

  always_comb begin
    outstanding_next = outstanding;
    if (grant && !retire)      outstanding_next = outstanding + CNT_W'(1);
    else if (!grant && retire) outstanding_next = outstanding - CNT_W'(1);
  end

  assign sm_valid_next = grant || (sm_valid && !sm_ready);

  // Drain completes on the post-update view so drain_done rises the cycle after the last retire.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= RUN;
      drain_done  <= 1'b0;
      rr_ptr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      sm_valid    <= 1'b0;
      sm_payload  <= '0;
    end else begin
      outstanding <= outstanding_next;
      sm_valid    <= sm_valid_next;
      if (grant) begin
        sm_payload <= grant_payload;
        wr_ptr     <= wr_ptr + PTR_W'(1);
        rr_ptr     <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
      end
      if (retire) rd_ptr <= rd_ptr + PTR_W'(1);
      case (state)
        RUN: begin
          if (drain_req) state <= DRAIN;
        end
        DRAIN: begin
          if (outstanding_next == '0 && !sm_valid_next) begin
            state      <= DRAINED;
            drain_done <= 1'b1;
          end
        end
        DRAINED: begin
          if (!drain_req) begin
            state      <= RUN;
            drain_done <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          drain_done <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (grant) id_fifo[wr_ptr] <= grant_id;
  end

endmodule
`default_nettype wire

// File: tb/tb_scratchpad_memory_arbiter.sv
`default_nettype none
// tb_scratchpad_memory_arbiter: directed and random stimulus checked against a queue-based
// reference model, with a payload scoreboard on stage-1 transfers.
module tb_scratchpad_memory_arbiter;
  localparam int N  = 2;
  localparam int PW = 64;
  localparam int MO = 4;
  localparam int CW = $clog2(MO+1);

  logic            clock = 1'b0;
  logic            resetn;
  logic [N-1:0]    req_valid;
  logic [N*PW-1:0] req_payload;
  logic [N-1:0]    req_ready;
  logic            sm_valid;
  logic [PW-1:0]   sm_payload;
  logic            sm_ready;
  logic            rsp_valid;
  logic            rsp_is_last;
  logic [N-1:0]    rsp_valid_out;
  logic [N-1:0]    rsp_last_out;
  logic            drain_req;
  logic            drain_done;
  logic [CW-1:0]   outstanding;

  scratchpad_memory_arbiter #(.NUM_REQ(N), .PAYLOAD_W(PW), .MAX_OUTSTANDING(MO)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_payload(req_payload), .req_ready(req_ready),
    .sm_valid(sm_valid), .sm_payload(sm_payload), .sm_ready(sm_ready),
    .rsp_valid(rsp_valid), .rsp_is_last(rsp_is_last),
    .rsp_valid_out(rsp_valid_out), .rsp_last_out(rsp_last_out),
    .drain_req(drain_req), .drain_done(drain_done), .outstanding(outstanding)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: state 0=running, 1=draining, 2=drained; queue of owner ids in grant order.
  int            m_state;
  int            m_rr;
  int            idq[$];
  bit            m_smv;
  logic [PW-1:0] m_pay;
  logic [PW-1:0] sm_q[$];

  always @(negedge clock) begin : model_proc
    int          g;
    int          h;
    bit          can;
    logic [63:0] erdy, erv, erl;
    if (!resetn) begin
      m_state = 0; m_rr = 0; m_smv = 1'b0; m_pay = '0;
      idq.delete(); sm_q.delete();
      chk("rst_outstanding", 64'(outstanding), 0);
      chk("rst_sm_valid", 64'(sm_valid), 0);
      chk("rst_sm_payload", sm_payload, 0);
      chk("rst_drain_done", 64'(drain_done), 0);
    end else begin
      can = (m_state == 0) && (!m_smv || sm_ready) && (idq.size() < MO);
      g = -1;
      if (can)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
      erdy = (g >= 0) ? (64'd1 << g) : 64'd0;
      erv = 0; erl = 0;
      if (rsp_valid && idq.size() > 0) begin
        h = idq[0];
        erv = 64'd1 << h;
        if (rsp_is_last) erl = 64'd1 << h;
      end
      chk("req_ready", 64'(req_ready), erdy);
      chk("rsp_valid_out", 64'(rsp_valid_out), erv);
      chk("rsp_last_out", 64'(rsp_last_out), erl);
      chk("outstanding", 64'(outstanding), 64'(idq.size()));
      chk("sm_valid", 64'(sm_valid), 64'(m_smv));
      chk("drain_done", 64'(drain_done), (m_state == 2) ? 64'd1 : 64'd0);
      if (m_smv) chk("sm_payload_reg", sm_payload, m_pay);
      // next-cycle model state
      if (rsp_valid && rsp_is_last && idq.size() > 0) void'(idq.pop_front());
      if (g >= 0) begin
        idq.push_back(g);
        m_rr  = (g + 1) % N;
        m_smv = 1'b1;
        m_pay = req_payload[g*PW +: PW];
        sm_q.push_back(m_pay);
      end else if (sm_ready) begin
        m_smv = 1'b0;
      end
      case (m_state)
        0: if (drain_req) m_state = 1;
        1: if (idq.size() == 0 && !m_smv) m_state = 2;
        default: if (!drain_req) m_state = 0;
      endcase
    end
  end

  // Scoreboard monitor: every stage-1 transfer must carry the oldest granted payload.
  always @(negedge clock) begin : monitor_proc
    logic [PW-1:0] e;
    if (resetn && sm_valid && sm_ready) begin
      if (sm_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sm_xfer: unexpected transfer payload %0h, none expected", sm_payload);
      end else begin
        e = sm_q.pop_front();
        chk("sm_xfer_payload", sm_payload, e);
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic rnd_payloads();
    for (int i = 0; i < N; i++) req_payload[i*PW +: PW] = {$urandom, $urandom};
  endtask

  task automatic flush();
    req_valid = '0; sm_ready = 1'b1; drain_req = 1'b0;
    rsp_valid = 1'b1; rsp_is_last = 1'b1;
    repeat (6) step();
    rsp_valid = 1'b0; rsp_is_last = 1'b0;
    step();
  endtask

  initial begin
    resetn = 1'b0; req_valid = '0; req_payload = '0; sm_ready = 1'b1;
    rsp_valid = 1'b0; rsp_is_last = 1'b0; drain_req = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
    step();

    // Both requesters always valid, responses retiring continuously
    req_valid = 2'b11;
    for (int c = 0; c < 20; c++) begin
      rnd_payloads();
      rsp_valid = (c >= 3); rsp_is_last = 1'b1;
      step();
    end
    flush();

    // Outstanding limit with a single requester and no responses
    req_valid = 2'b01;
    repeat (8) begin rnd_payloads(); step(); end
    chk("outstanding_full", 64'(outstanding), 64'd4);
    chk("ready_blocked_full", 64'(req_ready), 64'd0);
    rsp_valid = 1'b1; rsp_is_last = 1'b1;
    step();
    rsp_valid = 1'b0;
    repeat (3) step();
    flush();

    // Stage-1 stall holds the payload
    req_valid = 2'b01; req_payload[0 +: PW] = 64'hA5;
    step();
    req_valid = 2'b11; sm_ready = 1'b0;
    repeat (5) begin rnd_payloads(); step(); end
    chk("hold_payload", sm_payload, 64'hA5);
    chk("hold_valid", 64'(sm_valid), 64'd1);
    sm_ready = 1'b1; req_valid = '0;
    step();
    flush();

    // Multi-pass responses routed to owners in grant order 1,0
    rnd_payloads();
    req_valid = 2'b10; step();
    req_valid = 2'b01; step();
    req_valid = 2'b00; step();
    for (int p = 0; p < 4; p++) begin
      rsp_valid = 1'b1; rsp_is_last = p[0];
      step();
    end
    rsp_valid = 1'b0; rsp_is_last = 1'b0;
    step();
    flush();

    // Drain with two outstanding
    rnd_payloads();
    req_valid = 2'b01; step();
    req_valid = 2'b10; step();
    req_valid = 2'b00; drain_req = 1'b1; step();
    req_valid = 2'b11;
    repeat (3) step();
    rsp_valid = 1'b1; rsp_is_last = 1'b1;
    repeat (2) step();
    rsp_valid = 1'b0; rsp_is_last = 1'b0;
    step();
    chk("drain_done_after_retire", 64'(drain_done), 64'd1);
    drain_req = 1'b0;
    repeat (3) step();
    flush();

    // Response with empty FIFO, then reset with three outstanding
    rsp_valid = 1'b1; rsp_is_last = 1'b0; step();
    rsp_valid = 1'b0;
    req_valid = 2'b01;
    repeat (3) begin rnd_payloads(); step(); end
    req_valid = '0;
    resetn = 1'b0;
    step();
    chk("reset_outstanding", 64'(outstanding), 64'd0);
    chk("reset_sm_valid", 64'(sm_valid), 64'd0);
    resetn = 1'b1;
    rsp_valid = 1'b1; rsp_is_last = 1'b1;
    step();
    rsp_valid = 1'b0; rsp_is_last = 1'b0;
    step();

    // Randomized traffic with occasional drain requests and resets
    for (int c = 0; c < 1500; c++) begin
      req_valid   = N'($urandom);
      rnd_payloads();
      sm_ready    = ($urandom_range(3) != 0);
      rsp_valid   = ($urandom_range(4) < 2);
      rsp_is_last = ($urandom_range(4) < 3);
      if ($urandom_range(19) == 0) drain_req = ~drain_req;
      resetn      = ($urandom_range(199) != 0);
      step();
    end
    resetn = 1'b1;
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
